// File: rtl/usb_instr_bridge_ctrl_pkg.sv
// Shared register map, bit positions and FSM encoding for the CW305 instruction bridge.
package cw305_bridge_pkg;

  localparam int unsigned REG_INSTR  = 0;
  localparam int unsigned REG_CTRL   = 1;
  localparam int unsigned REG_STATUS = 2;
  localparam int unsigned REG_RESP   = 3;

  localparam int unsigned CTRL_GO    = 0;
  localparam int unsigned CTRL_ABORT = 1;
  localparam int unsigned CTRL_CLEAR = 2;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_IVALID  = 1;
  localparam int unsigned STAT_DONE    = 2;
  localparam int unsigned STAT_TIMEOUT = 3;
  localparam int unsigned STAT_OVR     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RESP,
    ST_DONE,
    ST_ERROR
  } bridge_state_e;

endpackage

// File: rtl/usb_instr_bridge_ctrl_timeout_cnt.sv
// Response-wait counter: held at zero while cleared, flags the terminal count while enabled.
module bridge_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = i_en && !i_clr && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/usb_instr_bridge_ctrl.sv
// Host-register to valid/ready instruction bridge with response capture and pollable status.
// Optional response timeout enabled by defining BRIDGE_TIMEOUT_EN.
module usb_instr_bridge_ctrl
  import cw305_bridge_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH    = 21,
  parameter int unsigned pBYTECNT_SIZE  = 2,
  parameter int unsigned pINSTR_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [pADDR_WIDTH-1:0]   reg_addr_i,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt_i,
  input  logic [7:0]               reg_wrdata_i,
  input  logic                     reg_write_i,
  input  logic                     reg_read_i,
  output logic [7:0]               reg_rddata_o,
  output logic [pINSTR_WIDTH-1:0]  instr_o,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  input  logic [pINSTR_WIDTH-1:0]  resp_i,
  input  logic                     resp_valid_i,
  output logic [7:0]               status_o
);

  if (pINSTR_WIDTH != 8 * (2 ** pBYTECNT_SIZE)) begin : g_bad_width
    $error("pINSTR_WIDTH must equal 8 * 2**pBYTECNT_SIZE");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  bridge_state_e r_state, w_state_nxt;

  logic [pINSTR_WIDTH-1:0]  r_instr;
  logic [pINSTR_WIDTH-1:0]  r_resp;
  logic [7:0]               r_rddata;
  logic                     r_done;
  logic                     r_ovr;
  logic [7:0]               w_status;
  logic [7:0]               w_rd_byte;
  logic [pBYTECNT_SIZE+2:0] w_lane_sh;
  logic w_sel_instr, w_sel_ctrl, w_sel_status, w_sel_resp;
  logic w_instr_wr, w_ctrl_wr, w_go, w_abort, w_clear;
  logic w_busy, w_ivalid, w_enter_issue, w_resp_cap, w_tmo_hit;
  logic w_tc, w_tmo;

  assign w_sel_instr  = (reg_addr_i == pADDR_WIDTH'(REG_INSTR));
  assign w_sel_ctrl   = (reg_addr_i == pADDR_WIDTH'(REG_CTRL));
  assign w_sel_status = (reg_addr_i == pADDR_WIDTH'(REG_STATUS));
  assign w_sel_resp   = (reg_addr_i == pADDR_WIDTH'(REG_RESP));
  assign w_lane_sh    = {reg_bytecnt_i, 3'b000};

  assign w_instr_wr = reg_write_i && w_sel_instr;
  assign w_ctrl_wr  = reg_write_i && w_sel_ctrl;
  assign w_abort    = w_ctrl_wr && reg_wrdata_i[CTRL_ABORT];
  assign w_go       = w_ctrl_wr && reg_wrdata_i[CTRL_GO] && !w_abort;
  assign w_clear    = w_ctrl_wr && reg_wrdata_i[CTRL_CLEAR];

  assign w_busy   = (r_state == ST_ISSUE) || (r_state == ST_WAIT_RESP);
  assign w_ivalid = (r_state == ST_ISSUE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ABORT overrides every other transition; a response beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: if (w_go) w_state_nxt = ST_ISSUE;
        ST_ISSUE:                   if (instr_ready_i) w_state_nxt = ST_WAIT_RESP;
        ST_WAIT_RESP: begin
          if (resp_valid_i) begin
            w_state_nxt = ST_DONE;
          end else if (w_tc) begin
            w_state_nxt = ST_ERROR;
          end
        end
        default:                    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_enter_issue = (w_state_nxt == ST_ISSUE) && (r_state != ST_ISSUE);
  assign w_resp_cap    = (r_state == ST_WAIT_RESP) && (w_state_nxt == ST_DONE);
  assign w_tmo_hit     = (r_state == ST_WAIT_RESP) && (w_state_nxt == ST_ERROR);

`ifdef BRIDGE_TIMEOUT_EN
  logic r_tmo;

  bridge_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo_cnt (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_clr (r_state != ST_WAIT_RESP),
    .i_en  (r_state == ST_WAIT_RESP),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tmo <= 1'b0;
    end else if (w_enter_issue) begin
      r_tmo <= 1'b0;
    end else if (w_tmo_hit) begin
      r_tmo <= 1'b1;
    end else if (w_clear && !w_busy) begin
      r_tmo <= 1'b0;
    end
  end

  assign w_tmo = r_tmo;
`else
  assign w_tc  = 1'b0;
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_enter_issue) begin
        r_done <= 1'b0;
      end else if (w_resp_cap) begin
        r_done <= 1'b1;
      end else if (w_clear && !w_busy) begin
        r_done <= 1'b0;
      end
      if (w_instr_wr && w_busy) begin
        r_ovr <= 1'b1;
      end else if (w_clear) begin
        r_ovr <= 1'b0;
      end
    end
  end

  // INSTR only accepts host bytes while idle so instr_o stays stable across the handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instr <= '0;
      r_resp  <= '0;
    end else begin
      if (w_instr_wr && !w_busy) begin
        r_instr[w_lane_sh +: 8] <= reg_wrdata_i;
      end
      if (w_resp_cap) begin
        r_resp <= resp_i;
      end
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[STAT_BUSY]     = w_busy;
    w_status[STAT_IVALID]   = w_ivalid;
    w_status[STAT_DONE]     = r_done;
    w_status[STAT_TIMEOUT]  = w_tmo;
    w_status[STAT_OVR]      = r_ovr;
  end

  always_comb begin
    w_rd_byte = 8'h00;
    if (w_sel_instr) begin
      w_rd_byte = r_instr[w_lane_sh +: 8];
    end else if (w_sel_status) begin
      w_rd_byte = w_status;
    end else if (w_sel_resp) begin
      w_rd_byte = r_resp[w_lane_sh +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rddata <= 8'h00;
    end else if (reg_read_i) begin
      r_rddata <= w_rd_byte;
    end
  end

  assign reg_rddata_o  = r_rddata;
  assign instr_o       = r_instr;
  assign instr_valid_o = w_ivalid;
  assign status_o      = w_status;

endmodule

// File: tb/tb_usb_instr_bridge_ctrl.sv
// Directed scoreboard bench for usb_instr_bridge_ctrl (timeout steps run when BRIDGE_TIMEOUT_EN is defined).
module tb_usb_instr_bridge_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [20:0] reg_addr = '0;
  logic [1:0]  reg_bytecnt = '0;
  logic [7:0]  reg_wrdata = '0;
  logic        reg_write = 1'b0;
  logic        reg_read = 1'b0;
  logic [7:0]  reg_rddata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] resp = '0;
  logic        resp_valid = 1'b0;
  logic [7:0]  status;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] sb_q[$];

  usb_instr_bridge_ctrl #(
    .pADDR_WIDTH   (21),
    .pBYTECNT_SIZE (2),
    .pINSTR_WIDTH  (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .reg_addr_i   (reg_addr),
    .reg_bytecnt_i(reg_bytecnt),
    .reg_wrdata_i (reg_wrdata),
    .reg_write_i  (reg_write),
    .reg_read_i   (reg_read),
    .reg_rddata_o (reg_rddata),
    .instr_o      (instr),
    .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready),
    .resp_i       (resp),
    .resp_valid_i (resp_valid),
    .status_o     (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [20:0] a, input logic [1:0] l, input logic [7:0] d);
    @(negedge clk);
    reg_addr = a; reg_bytecnt = l; reg_wrdata = d; reg_write = 1'b1;
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic rd(input logic [20:0] a, input logic [1:0] l, input logic [7:0] exp,
                    input string tag);
    @(negedge clk);
    reg_addr = a; reg_bytecnt = l; reg_read = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    reg_read = 1'b0;
    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    else chk(tag, {24'h0, reg_rddata}, {24'h0, sb_q.pop_front()});
  endtask

  task automatic pulse_resp(input logic [31:0] d);
    @(negedge clk);
    resp = d; resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    // reset state
    idle(2);
    chk("rst_status", {24'h0, status}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_rddata", {24'h0, reg_rddata}, 32'h0);
    rst = 1'b0;

    // load instruction, issue with immediate acceptance
    wr(21'd0, 2'd0, 8'h13);
    wr(21'd0, 2'd1, 8'h05);
    wr(21'd0, 2'd2, 8'h50);
    wr(21'd0, 2'd3, 8'h00);
    rd(21'd0, 2'd2, 8'h50, "instr_lane2_rd");
    instr_ready = 1'b1;
    wr(21'd1, 2'd0, 8'h01);
    chk("issue_valid", {31'h0, instr_valid}, 32'h1);
    chk("issue_instr", instr, 32'h00500513);
    @(negedge clk);
    chk("accept_valid_drop", {31'h0, instr_valid}, 32'h0);
    rd(21'd2, 2'd0, 8'h01, "wait_status");

    pulse_resp(32'hDEADBEEF);
    chk("done_status", {24'h0, status}, 32'h04);
    rd(21'd2, 2'd0, 8'h04, "done_status_rd");
    rd(21'd3, 2'd0, 8'hEF, "resp_l0");
    rd(21'd3, 2'd1, 8'hBE, "resp_l1");
    rd(21'd3, 2'd2, 8'hAD, "resp_l2");
    rd(21'd3, 2'd3, 8'hDE, "resp_l3");
    rd(21'd5, 2'd0, 8'h00, "unmapped_rd");

    // consumer stalls; overwrite attempt while busy
    instr_ready = 1'b0;
    wr(21'd1, 2'd0, 8'h01);
    chk("stall_status", {24'h0, status}, 32'h03);
    wr(21'd0, 2'd0, 8'hFF);
    chk("ovr_instr_kept", instr, 32'h00500513);
    chk("ovr_status", {24'h0, status}, 32'h13);
    rd(21'd2, 2'd0, 8'h13, "ovr_status_rd");
    wr(21'd1, 2'd0, 8'h04);
    chk("clear_busy_status", {24'h0, status}, 32'h03);
    wr(21'd1, 2'd0, 8'h01);
    chk("go_while_busy", {24'h0, status}, 32'h03);

    // GO+ABORT while in ISSUE
    wr(21'd1, 2'd0, 8'h03);
    chk("abort_valid", {31'h0, instr_valid}, 32'h0);
    chk("abort_status", {24'h0, status}, 32'h00);
    rd(21'd3, 2'd0, 8'hEF, "abort_keeps_resp");
    pulse_resp(32'h12345678);
    chk("stray_resp_status", {24'h0, status}, 32'h00);
    rd(21'd3, 2'd3, 8'hDE, "stray_resp_ignored");

`ifdef BRIDGE_TIMEOUT_EN
    // no response: ERROR on the 16th WAIT_RESP cycle edge
    instr_ready = 1'b1;
    wr(21'd1, 2'd0, 8'h01);
    idle(16);
    chk("tmo_pre_status", {24'h0, status}, 32'h01);
    @(negedge clk);
    chk("tmo_status", {24'h0, status}, 32'h08);
    wr(21'd1, 2'd0, 8'h04);
    chk("tmo_clear_status", {24'h0, status}, 32'h00);
    // response on the terminal cycle wins
    wr(21'd1, 2'd0, 8'h01);
    idle(15);
    pulse_resp(32'hCAFEF00D);
    chk("tmo_race_status", {24'h0, status}, 32'h04);
    rd(21'd3, 2'd0, 8'h0D, "tmo_race_resp");
`else
    // no timeout: WAIT_RESP persists until ABORT
    instr_ready = 1'b1;
    wr(21'd1, 2'd0, 8'h01);
    idle(40);
    chk("no_tmo_status", {24'h0, status}, 32'h01);
    wr(21'd1, 2'd0, 8'h02);
    chk("no_tmo_abort", {24'h0, status}, 32'h00);
`endif

    // asynchronous reset in WAIT_RESP
    wr(21'd1, 2'd0, 8'h01);
    @(negedge clk);
    rd(21'd2, 2'd0, 8'h01, "pre_rst_status");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_status", {24'h0, status}, 32'h0);
    chk("arst_valid", {31'h0, instr_valid}, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_rddata", {24'h0, reg_rddata}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    instr_ready = 1'b0;
    rd(21'd0, 2'd0, 8'h00, "arst_instr_rd");
    rd(21'd3, 2'd3, 8'h00, "arst_resp_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/usb_instr_bridge_ctrl.md
Name: usb_instr_bridge_ctrl

Overview:
Controller between the CW305 USB register interface and the X-HEEP-side instruction consumer. The host writes a 32-bit instruction byte by byte and issues GO. The block presents the word on a valid/ready handshake, waits for the consumer's response and captures it. It exposes a status register that the host polls; status bit 1 drives the bridge instruction-valid indication used by the testbench.

Parameters:
pADDR_WIDTH, 21, width of host register address
pBYTECNT_SIZE, 2, width of byte-lane index within a register
pINSTR_WIDTH, 32, instruction/response word width; must equal 8 * 2**pBYTECNT_SIZE
TIMEOUT_CYCLES, 1024, response wait limit in clk_i cycles (only with BRIDGE_TIMEOUT_EN)

Ports:
clk_i  in  1  single clock for all logic
rst_i  in  1  asynchronous, active-high reset
reg_addr_i  in  pADDR_WIDTH  host register address
reg_bytecnt_i  in  pBYTECNT_SIZE  byte lane of the access
reg_wrdata_i  in  8  host write byte
reg_write_i  in  1  one-cycle write strobe
reg_read_i  in  1  one-cycle read strobe
reg_rddata_o  out  8  read byte, valid 1 cycle after reg_read_i
instr_o  out  pINSTR_WIDTH  instruction word to consumer
instr_valid_o  out  1  instruction offered
instr_ready_i  in  1  consumer accepts
resp_i  in  pINSTR_WIDTH  consumer response word
resp_valid_i  in  1  response valid (single-cycle pulse sufficient)
status_o  out  8  live status register

Behaviour:
- Register map: 0 = INSTR (W/R, 4 lanes); 1 = CTRL (W: bit0 GO, bit1 ABORT, bit2 CLEAR); 2 = STATUS (R); 3 = RESP (R, 4 lanes). Unmapped reads return 0x00; unmapped writes are ignored.
- STATUS bits: 0 busy, 1 instr_valid, 2 done, 3 timeout, 4 overwrite_err, 7:5 = 0.
- Reset values: all outputs 0; INSTR and RESP registers 0; state IDLE.
- FSM states: IDLE, ISSUE, WAIT_RESP, DONE, ERROR.
  - IDLE/DONE/ERROR + GO -> ISSUE. Entering ISSUE clears done and timeout.
  - ISSUE: instr_valid_o=1; instr_o is stable. instr_valid_o && instr_ready_i -> WAIT_RESP on the next cycle, with instr_valid_o=0. Acceptance in the first ISSUE cycle is legal, so GO to valid takes 1 cycle.
  - WAIT_RESP + resp_valid_i -> DONE. RESP captures resp_i on the same edge; done=1.
  - WAIT_RESP + timeout terminal count -> ERROR; timeout=1.
- busy=1 in ISSUE and WAIT_RESP.
- Writes to INSTR while busy: data is discarded and overwrite_err=1 (sticky).
- GO while busy is ignored.
- CLEAR clears done, timeout and overwrite_err in non-busy states. In busy states it clears overwrite_err only.
- ABORT from any state -> IDLE next cycle. It drops instr_valid_o without handshake, clears busy, and keeps RESP.
- Simultaneous events:
  - GO+ABORT in the same write: ABORT wins.
  - resp_valid_i on the timeout terminal cycle: the response wins (DONE).
  - resp_valid_i outside WAIT_RESP is ignored.
- Reads are registered: reg_rddata_o is updated on the cycle after reg_read_i and holds until the next read.
- Reset asserted mid-operation returns everything to reset values immediately (async).

Optional Feature:
BRIDGE_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT_RESP and increments each cycle. When count == TIMEOUT_CYCLES-1 without a response, the FSM goes to ERROR.
- Undefined: no counter; WAIT_RESP waits indefinitely (ABORT is the only exit other than a response); status bit 3 is constant 0; TIMEOUT_CYCLES is unused.

Decomposition:
- cw305_bridge_pkg holds: register address localparams (REG_INSTR, REG_CTRL, REG_STATUS, REG_RESP), CTRL bit indices, STATUS bit indices, and the bridge_state_e enum.
- One natural sub-module, bridge_timeout_cnt: clear/enable/terminal-count, instantiated only under BRIDGE_TIMEOUT_EN.

Test Plan:
- Write INSTR lanes 0..3 = 0x13,0x05,0x50,0x00, then GO with instr_ready_i=1 -> instr_valid_o high for exactly 1 cycle with instr_o=0x00500513; STATUS reads 0x01 while waiting.
- Drive resp_valid_i with resp_i=0xDEADBEEF -> STATUS=0x04; RESP lanes 0..3 read 0xEF,0xBE,0xAD,0xDE.
- Hold instr_ready_i=0 and write INSTR lane 0=0xFF -> instr_o unchanged; STATUS=0x13; after CLEAR, STATUS=0x03.
- With BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, no response -> ERROR after 16 cycles in WAIT_RESP; STATUS=0x08. Repeat with resp_valid_i on cycle 16 -> STATUS=0x04.
- Write CTRL=0x03 (GO+ABORT) in ISSUE -> next cycle IDLE, instr_valid_o=0, STATUS=0x00.
- Assert rst_i in WAIT_RESP mid-cycle -> all outputs 0 immediately; INSTR/RESP read 0x00.
